// File: rtl/idct_split_ser_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : idct_split_ser_if                                           |
// | Brief  : Block input (sums/differences) and serial sample output bus |
// | Rev    : 1.0                                                         |
// +----------------------------------------------------------------------+
interface idct_split_ser_if #(
    parameter int IN_W  = 18,
    parameter int OUT_W = 15
);
    logic signed [IN_W-1:0]  s0, s1, s2, s3;
    logic signed [IN_W-1:0]  d0, d1, d2, d3;
    logic                    in_valid;
    logic                    in_ready;
    logic signed [OUT_W-1:0] out;
    logic                    out_valid;
    logic                    out_last;
    logic                    sat;

    modport master (
        output s0, s1, s2, s3, d0, d1, d2, d3, in_valid,
        input  in_ready, out, out_valid, out_last, sat
    );

    modport slave (
        input  s0, s1, s2, s3, d0, d1, d2, d3, in_valid,
        output in_ready, out, out_valid, out_last, sat
    );
endinterface
`default_nettype wire

// File: rtl/idct_split_ser.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : idct_split_ser                                              |
// | Brief  : Final IDCT butterfly split, emits x0..x7 serially, saturated|
// | Rev    : 1.0                                                         |
// +----------------------------------------------------------------------+
module idct_split_ser #(
    parameter int IN_W  = 18,
    parameter int OUT_W = 15
) (
    input  wire logic          clk,
    input  wire logic          rst,
    idct_split_ser_if.slave    bus
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t r_state;
    state_t w_state_next;
    logic [2:0] r_idx;
    logic [2:0] w_idx_next;

    logic signed [IN_W-1:0] r_s [4];
    logic signed [IN_W-1:0] r_d [4];

    logic w_in_ready;
    logic w_accept;
    logic w_last;

    logic [1:0]           w_k;
    logic signed [IN_W:0] w_a;
    logic signed [IN_W:0] w_b;
    logic signed [IN_W:0] w_res;
    logic signed [IN_W:0] w_shr;
    logic                 w_fit;
    logic [OUT_W-1:0]     w_clip;

    assign w_last     = (r_state == SEND) && (r_idx == 3'd7);
    assign w_in_ready = (r_state == IDLE) || w_last;
    assign w_accept   = bus.in_valid && w_in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_idx   <= 3'd0;
        end else begin
            r_state <= w_state_next;
            r_idx   <= w_idx_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_idx_next   = r_idx;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_next = SEND;
                    w_idx_next   = 3'd0;
                end
            end
            SEND: begin
                if (r_idx == 3'd7) begin
                    // A block accepted on the last sample continues without a bubble
                    w_state_next = w_accept ? SEND : IDLE;
                    w_idx_next   = 3'd0;
                end else begin
                    w_idx_next = r_idx + 3'd1;
                end
            end
            default: begin
                w_state_next = IDLE;
                w_idx_next   = 3'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                r_s[i] <= '0;
                r_d[i] <= '0;
            end
        end else if (w_accept) begin
            r_s[0] <= bus.s0;
            r_s[1] <= bus.s1;
            r_s[2] <= bus.s2;
            r_s[3] <= bus.s3;
            r_d[0] <= bus.d0;
            r_d[1] <= bus.d1;
            r_d[2] <= bus.d2;
            r_d[3] <= bus.d3;
        end
    end

    // x4..x7 walk the pairs in reverse, so the pair index is the inverted low bits
    assign w_k   = r_idx[2] ? ~r_idx[1:0] : r_idx[1:0];
    assign w_a   = {r_s[w_k][IN_W-1], r_s[w_k]};
    assign w_b   = {r_d[w_k][IN_W-1], r_d[w_k]};
    assign w_res = r_idx[2] ? (w_a - w_b) : (w_a + w_b);
    assign w_shr = w_res >>> 1;

    // The value fits when every bit above the output sign bit matches it
    assign w_fit  = (&w_shr[IN_W:OUT_W-1]) | ~(|w_shr[IN_W:OUT_W-1]);
    assign w_clip = w_fit ? w_shr[OUT_W-1:0]
                          : {w_shr[IN_W], {(OUT_W-1){~w_shr[IN_W]}}};

    always_comb begin
        bus.out       = '0;
        bus.out_valid = 1'b0;
        bus.out_last  = 1'b0;
        bus.sat       = 1'b0;
        if (r_state == SEND) begin
            bus.out       = w_clip;
            bus.out_valid = 1'b1;
            bus.out_last  = w_last;
            bus.sat       = ~w_fit;
        end
    end

    assign bus.in_ready = w_in_ready;

endmodule
`default_nettype wire

// File: doc/idct_split_ser.md
IDCT_SPLIT_SER -- requirements
Module: idct_split_ser

Interface
REQ-001 SHALL have parameter IN_W, default 18, width of the signed sum/difference inputs (Q8.10).
REQ-002 SHALL have parameter OUT_W, default 15, width of the signed serial output sample (Q5.10).
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have ports s0, s1, s2, s3  input  IN_W each  butterfly sums, two's complement.
REQ-006 SHALL have ports d0, d1, d2, d3  input  IN_W each  butterfly differences, two's complement.
REQ-007 SHALL have port in_valid  input  1  s0..s3 and d0..d3 hold a valid block.
REQ-008 SHALL have port in_ready  output  1  block accepted on an edge where in_valid and in_ready are both high.
REQ-009 SHALL have port out  output  OUT_W  reconstructed serial sample.
REQ-010 SHALL have port out_valid  output  1  out carries a valid sample this cycle.
REQ-011 SHALL have port out_last  output  1  out carries sample x7 of the block.
REQ-012 SHALL have port sat  output  1  the current out sample was clipped.

Function
REQ-013 SHALL register all eight inputs on acceptance and SHALL ignore input changes until the next acceptance.
REQ-014 SHALL use states IDLE and SEND; IDLE -> SEND on acceptance; SEND -> IDLE after x7 unless a new block is accepted on the same edge.
REQ-015 SHALL drive in_ready high in IDLE and during the SEND cycle where out_last=1, and low otherwise.
REQ-016 SHALL emit eight samples on consecutive cycles in the order x0..x7, with no stall input.
REQ-017 SHALL assert out_valid with x0 on the first cycle after the acceptance edge, giving 1-cycle latency.
REQ-018 SHALL hold out_valid high for exactly 8 cycles per block and assert out_last only alongside x7.
REQ-019 SHALL compute x0..x3 as (s0+d0), (s1+d1), (s2+d2), (s3+d3), each arithmetic-shifted right by 1.
REQ-020 SHALL compute x4..x7 as (s3-d3), (s2-d2), (s1-d1), (s0-d0), each arithmetic-shifted right by 1.
REQ-021 SHALL form each sum/difference at IN_W+1 bits before the shift, so there is no intermediate overflow.
REQ-022 SHALL round by floor: a plain arithmetic shift, no rounding constant.
REQ-023 SHALL saturate the shifted result to the signed OUT_W range [-16384, 16383] for default widths.
REQ-024 SHALL assert sat for exactly the samples that were clipped.
REQ-025 SHALL, on back-to-back acceptance during out_last, output the new block's x0 on the next cycle with out_valid held high (no bubble).
REQ-026 SHALL drive out, out_last and sat to 0 whenever out_valid is 0.
REQ-027 SHALL keep the sample index as a 3-bit counter that wraps from 7 to 0 only at block end.

Reset
REQ-028 SHALL, on an edge where rst=1, enter IDLE and clear the counter and all input registers.
REQ-029 SHALL have these output values after that edge: out=0, out_valid=0, out_last=0, sat=0, in_ready=1.
REQ-030 SHALL, when rst is asserted mid-block, discard the remaining samples, and out_valid SHALL be 0 from the next cycle.
REQ-031 SHALL let rst take priority over a simultaneous in_valid, so that block is not accepted.

Verification
REQ-032 Basic: s0=3072, d0=1024, all other inputs 0, one in_valid pulse -> out x0=2048, x1..x6=0, x7=1024; out_valid high 8 cycles; out_last on x7.
REQ-033 Negative floor: s0=-2048, d0=-1025 -> x0=-1537, x7=-512, sat=0.
REQ-034 Saturation: s1=40000, d1=40000 -> x1=16383 with sat=1, x6=0 with sat=0; s1=d1=-40000 -> x1=-16384 with sat=1.
REQ-035 Back-to-back: second block presented while out_last=1 -> 16 consecutive out_valid cycles, out_last at cycles 8 and 16, in_ready high only at those cycles.
REQ-036 Reset mid-block: rst high for 1 cycle at sample x3 -> out_valid=0 from the next cycle, in_ready=1, then a fresh block restarts at x0.
REQ-037 Hold-off: in_valid held high during SEND with changing data -> only values present at acceptance edges appear on out.
